// File: rtl/ss_seq.sv
// ss_seq: save-state sequencer. Walks the mapper save-state bytes
// 0..SS_LEN-1, one m2 pulse per byte, copying them mapper -> buffer RAM
// (save) or buffer RAM -> mapper (load).
//
// Ports
//   clk, rst_n           clock (rising edge) and synchronous active-low reset
//   cmd_save/cmd_load    one-cycle start requests, honoured only in IDLE
//   cmd_abort            one-cycle stop request, honoured only while busy
//   busy, done, aborted  transfer in progress / completion pulses
//   ss_err, map_id       result of the last completed save
//   ss_act, ss_we, ss_m2 mapper save-state mode, write strobe and m2 clock
//   ss_addr, ss_wdat     mapper byte address and restore data
//   ss_rdat              mapper read data
//   buf_addr, buf_we,
//   buf_wdat, buf_rdat   buffer RAM port (read data 1 cycle after address)
//   dbg_state            current FSM state, for checkers
//
// Handshake: cmd_save/cmd_load are accepted only in a cycle where busy=0 and
// the FSM is idle; there is no ready back-pressure, a request seen while busy
// is simply dropped. Completion is signalled by exactly one of done/aborted
// pulsing for one cycle, in the same cycle busy falls.
module ss_seq #(
    parameter int SS_LEN  = 128,
    parameter int M2_HALF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_save,
    input  logic       cmd_load,
    input  logic       cmd_abort,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       ss_err,
    output logic [7:0] map_id,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic       ss_m2,
    output logic [7:0] buf_addr,
    output logic       buf_we,
    output logic [7:0] buf_wdat,
    input  logic [7:0] buf_rdat,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(M2_HALF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    idx;
    logic [CW-1:0] cnt;       // cycle within the current HIGH or LOW phase
    logic          is_save;
    logic          abort_q;   // abort seen during this transfer
    logic [7:0]    cap;       // byte captured from the mapper on last HIGH

    logic          in_xfer;
    logic          start_save;
    logic          start_load;
    logic          last_half;
    logic          last_byte;
    logic          abort_hit;

    always_comb begin
        in_xfer    = (state == SETUP) || (state == HIGH) || (state == LOW);
        start_save = (state == IDLE) && cmd_save;
        start_load = (state == IDLE) && cmd_load && !cmd_save;
        last_half  = (cnt == CW'(M2_HALF - 1));
        last_byte  = (idx == 8'(SS_LEN - 1));
        // An abort arriving on the final LOW cycle still counts for this slot.
        abort_hit  = abort_q || cmd_abort;

        state_nxt = state;
        unique case (state)
            IDLE:    if (start_save || start_load) state_nxt = SETUP;
            SETUP:   state_nxt = HIGH;
            HIGH:    if (last_half) state_nxt = LOW;
            LOW: begin
                if (last_half) begin
                    if (abort_hit || last_byte) state_nxt = FIN;
                    else                        state_nxt = SETUP;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy      = in_xfer;
        ss_act    = in_xfer;
        ss_m2     = (state == HIGH);
        // Held off for the first HIGH cycle so ss_wdat has settled first.
        ss_we     = !is_save && (((state == HIGH) && (cnt != '0)) || (state == LOW));
        buf_we    = is_save && (state == LOW) && (cnt == '0);
        done      = (state == FIN) && !abort_q;
        aborted   = (state == FIN) && abort_q;
        ss_addr   = idx;
        buf_addr  = idx;
        buf_wdat  = cap;
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= 8'h00;
            cnt     <= '0;
            is_save <= 1'b0;
            abort_q <= 1'b0;
            cap     <= 8'h00;
            ss_wdat <= 8'h00;
            map_id  <= 8'h00;
            ss_err  <= 1'b0;
        end else begin
            if ((state == HIGH) || (state == LOW)) cnt <= last_half ? '0 : cnt + 1'b1;
            else                                   cnt <= '0;

            if (start_save || start_load) begin
                idx     <= 8'h00;
                is_save <= start_save;
                abort_q <= 1'b0;
            end
            if (start_save) ss_err <= 1'b0;

            if (in_xfer && cmd_abort) abort_q <= 1'b1;

            if ((state == LOW) && last_half && !abort_hit && !last_byte)
                idx <= idx + 8'd1;

            if ((state == HIGH) && last_half && is_save)
                cap <= ss_rdat;

            // Buffer read data for idx arrives in the first HIGH cycle.
            if ((state == HIGH) && (cnt == '0) && !is_save)
                ss_wdat <= buf_rdat;

            // cap still holds the last byte here; an aborted save leaves the
            // previous map_id/ss_err result in place.
            if ((state == LOW) && last_half && is_save && !abort_hit && last_byte) begin
                map_id <= cap;
                ss_err <= (cap == 8'hff);
            end
        end
    end

endmodule

// File: tb/tb_ss_seq.sv
module tb_ss_seq;
    localparam int SS_LEN  = 128;
    localparam int M2_HALF = 2;
    localparam int XFER_CYC = 1 + SS_LEN * (1 + 2 * M2_HALF);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_save, cmd_load, cmd_abort;
    logic       busy, done, aborted, ss_err;
    logic [7:0] map_id;
    logic       ss_act, ss_we, ss_m2;
    logic [7:0] ss_addr, ss_wdat, ss_rdat;
    logic [7:0] buf_addr, buf_wdat, buf_rdat;
    logic       buf_we;
    logic [2:0] dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ss_seq #(.SS_LEN(SS_LEN), .M2_HALF(M2_HALF)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_save(cmd_save), .cmd_load(cmd_load), .cmd_abort(cmd_abort),
        .busy(busy), .done(done), .aborted(aborted), .ss_err(ss_err),
        .map_id(map_id), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .ss_m2(ss_m2),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdat(buf_wdat),
        .buf_rdat(buf_rdat), .dbg_state(dbg_state)
    );

    // ---------------- environment models ----------------
    logic [7:0] map_rtab [256];   // what the mapper returns per address
    logic [7:0] buf_mem  [256];   // buffer RAM contents

    assign ss_rdat = map_rtab[ss_addr];

    always @(posedge clk) begin
        if (buf_we) buf_mem[buf_addr] <= buf_wdat;
        buf_rdat <= buf_mem[buf_addr];
    end

    // ---------------- scoreboard ----------------
    logic [15:0] bw_exp_q[$];     // {addr, data} buffer writes
    logic [15:0] mw_exp_q[$];     // {addr, data} mapper negedge-m2 writes
    logic [1:0]  ev_exp_q[$];     // {done, aborted}

    int n_checks = 0;
    int n_errors = 0;
    int ncyc = 0;
    int n_complete = 0;
    int done_ncyc = 0;
    int cmd_ncyc = 0;
    int we_in_save = 0;
    int bad_strobe = 0;
    bit cur_is_save = 1'b0;
    logic prev_m2 = 1'b0;
    logic [15:0] mon_e;
    logic [1:0]  mon_ev;
    logic [7:0]  exp_map_id = 8'h00;
    logic        exp_ss_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h expected none (t=%0t)", name, act, $time);
    endtask

    // monitor: pops an expectation whenever the DUT presents an output event
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (buf_we === 1'b1) begin
            if (!cur_is_save || !ss_act || ss_m2) bad_strobe++;
            if (bw_exp_q.size() == 0) fail_now("buf_write_unexpected", 32'({buf_addr, buf_wdat}));
            else begin
                mon_e = bw_exp_q.pop_front();
                check("buf_write", 32'({buf_addr, buf_wdat}), 32'(mon_e));
            end
        end
        if (ss_we === 1'b1 && !ss_act) bad_strobe++;
        if (ss_we === 1'b1 && cur_is_save) we_in_save++;
        if (prev_m2 === 1'b1 && ss_m2 === 1'b0 && ss_we === 1'b1) begin
            if (mw_exp_q.size() == 0) fail_now("map_write_unexpected", 32'({ss_addr, ss_wdat}));
            else begin
                mon_e = mw_exp_q.pop_front();
                check("map_write", 32'({ss_addr, ss_wdat}), 32'(mon_e));
            end
        end
        prev_m2 = ss_m2;
        if (done === 1'b1 || aborted === 1'b1) begin
            n_complete++;
            done_ncyc = ncyc;
            if (ev_exp_q.size() == 0) fail_now("completion_unexpected", 32'({done, aborted}));
            else begin
                mon_ev = ev_exp_q.pop_front();
                check("completion", 32'({done, aborted}), 32'(mon_ev));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input bit save, input bit both);
        cur_is_save = save;
        cmd_save = save;
        cmd_load = !save || both;
        cmd_ncyc = ncyc;
        tick();
        cmd_save = 1'b0;
        cmd_load = 1'b0;
    endtask

    task automatic wait_complete(input int budget);
        int start;
        int g;
        start = n_complete;
        g = 0;
        while (n_complete == start && g < budget) begin
            tick();
            g++;
        end
        if (n_complete == start) fail_now("completion_timeout", 32'(g));
        tick();   // let FIN pass so the next command lands in IDLE
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_bw_drain"}, 32'(bw_exp_q.size()), 32'd0);
        check({tag, "_mw_drain"}, 32'(mw_exp_q.size()), 32'd0);
        check({tag, "_ev_drain"}, 32'(ev_exp_q.size()), 32'd0);
        check({tag, "_we_in_save"}, 32'(we_in_save), 32'd0);
        check({tag, "_bad_strobe"}, 32'(bad_strobe), 32'd0);
    endtask

    // One transfer: model its visible effects, run it, check the results.
    // abort_k < 0 means run to completion; otherwise abort inside slot abort_k.
    task automatic do_op(input bit save, input bit both, input int abort_k,
                         input bit abort_in_high, input bit noise, input string tag);
        int n;
        int g;
        n = (abort_k >= 0) ? abort_k + 1 : SS_LEN;
        for (int a = 0; a < n; a++) begin
            if (save) bw_exp_q.push_back({8'(a), map_rtab[a]});
            else      mw_exp_q.push_back({8'(a), buf_mem[a]});
        end
        ev_exp_q.push_back((abort_k >= 0) ? 2'b01 : 2'b10);
        start_op(save, both);
        if (noise) begin
            repeat (3) tick();
            cmd_load = 1'b1; tick(); cmd_load = 1'b0;
            repeat (7) tick();
            cmd_save = 1'b1; tick(); cmd_save = 1'b0;
        end
        if (abort_k >= 0) begin
            g = 0;
            while (!(busy && ss_addr == 8'(abort_k) && (!abort_in_high || ss_m2)) && g < 2000) begin
                tick();
                g++;
            end
            if (g >= 2000) fail_now({tag, "_abort_wait_timeout"}, 32'(g));
            if (!abort_in_high) repeat ($urandom_range(0, 1 + 2 * M2_HALF - 1)) tick();
            cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        end
        wait_complete(XFER_CYC + 100);
        if (abort_k < 0) check({tag, "_latency"}, 32'(done_ncyc - cmd_ncyc), 32'(XFER_CYC));
        if (save && abort_k < 0) begin
            exp_map_id = map_rtab[SS_LEN-1];
            exp_ss_err = (map_rtab[SS_LEN-1] == 8'hff);
        end
        check({tag, "_map_id"}, 32'(map_id), 32'(exp_map_id));
        if (!(save && abort_k >= 0)) check({tag, "_ss_err"}, 32'(ss_err), 32'(exp_ss_err));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_drained(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] sentinel;
        int g;
        bit op_save;
        int k;

        rst_n = 1'b0; cmd_save = 1'b0; cmd_load = 1'b0; cmd_abort = 1'b0;
        for (int a = 0; a < 256; a++) begin
            map_rtab[a] = 8'(a) ^ 8'h5a;
            buf_mem[a]  = 8'h00;
        end
        repeat (3) tick();

        // reset state
        check("rst_busy", 32'(busy), 0);       check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0); check("rst_ss_err", 32'(ss_err), 0);
        check("rst_map_id", 32'(map_id), 0);   check("rst_ss_act", 32'(ss_act), 0);
        check("rst_ss_we", 32'(ss_we), 0);     check("rst_ss_m2", 32'(ss_m2), 0);
        check("rst_buf_we", 32'(buf_we), 0);   check("rst_ss_addr", 32'(ss_addr), 0);
        check("rst_buf_addr", 32'(buf_addr), 0); check("rst_ss_wdat", 32'(ss_wdat), 0);
        check("rst_buf_wdat", 32'(buf_wdat), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // abort in idle does nothing
        cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        repeat (3) tick();
        check("idle_abort_busy", 32'(busy), 0);

        // save with addr^5A
        do_op(1'b1, 1'b0, -1, 1'b0, 1'b0, "save5a");
        check("save5a_map_id_const", 32'(map_id), 32'h25);
        for (int a = 0; a < SS_LEN; a++)
            check("save5a_buf", 32'(buf_mem[a]), 32'(8'(a) ^ 8'h5a));

        // load with buffer = ~addr
        for (int a = 0; a < 256; a++) buf_mem[a] = ~8'(a);
        do_op(1'b0, 1'b0, -1, 1'b0, 1'b0, "load_inv");

        // save and load together -> save; commands during busy ignored
        for (int a = 0; a < 256; a++) map_rtab[a] = 8'($urandom);
        do_op(1'b1, 1'b1, -1, 1'b0, 1'b1, "both");

        // map ID 8'hff -> ss_err; a later load keeps it
        for (int a = 0; a < 256; a++) map_rtab[a] = 8'(a) ^ 8'h5a;
        map_rtab[SS_LEN-1] = 8'hff;
        do_op(1'b1, 1'b0, -1, 1'b0, 1'b0, "save_ff");
        check("save_ff_err", 32'(ss_err), 32'd1);
        for (int a = 0; a < 256; a++) buf_mem[a] = 8'($urandom);
        do_op(1'b0, 1'b0, -1, 1'b0, 1'b0, "load_keep_err");
        check("load_keep_err_flag", 32'(ss_err), 32'd1);

        // abort during HIGH of byte 10 of a save
        for (int a = 0; a < 256; a++) map_rtab[a] = 8'($urandom);
        sentinel = 8'($urandom);
        buf_mem[11] = sentinel;
        do_op(1'b1, 1'b0, 10, 1'b1, 1'b0, "abort10");
        check("abort10_byte11", 32'(buf_mem[11]), 32'(sentinel));
        check("abort10_map_id_kept", 32'(map_id), 32'hff);

        // reset during HIGH of byte 3 of a load
        for (int a = 0; a < 256; a++) buf_mem[a] = 8'($urandom);
        for (int a = 0; a < 3; a++) mw_exp_q.push_back({8'(a), buf_mem[a]});
        start_op(1'b0, 1'b0);
        g = 0;
        while (!(ss_m2 && ss_addr == 8'd3) && g < 2000) begin tick(); g++; end
        if (g >= 2000) fail_now("rst_mid_wait_timeout", 32'(g));
        rst_n = 1'b0;
        tick();
        check("rst_mid_ss_m2", 32'(ss_m2), 0);
        check("rst_mid_ss_act", 32'(ss_act), 0);
        check("rst_mid_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        exp_map_id = 8'h00;
        exp_ss_err = 1'b0;
        check("rst_mid_map_id", 32'(map_id), 0);
        check_drained("rst_mid");

        // randomized transfers, some aborted at a random point
        for (int it = 0; it < 5; it++) begin
            op_save = 1'($urandom_range(0, 1));
            k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SS_LEN - 1)) : -1;
            for (int a = 0; a < 256; a++) begin
                map_rtab[a] = 8'($urandom);
                if (!op_save) buf_mem[a] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) map_rtab[SS_LEN-1] = 8'hff;
            do_op(op_save, 1'b0, k, 1'b0, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // overall watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ss_seq.md
SS_SEQ -- requirements
Module: ss_seq

Interface
REQ-001 SHALL have parameter SS_LEN, default 128, meaning the number of save-state bytes per transfer (addresses 0..SS_LEN-1, max 256).
REQ-002 SHALL have parameter M2_HALF, default 2, meaning the clk cycles per m2 half-period; legal values are 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port cmd_save, input, 1 bit: one-cycle request to dump mapper state into the buffer.
REQ-006 SHALL have port cmd_load, input, 1 bit: one-cycle request to restore mapper state from the buffer.
REQ-007 SHALL have port cmd_abort, input, 1 bit: one-cycle request to stop a transfer in progress.
REQ-008 SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-010 SHALL have port aborted, output, 1 bit: one-cycle pulse on abort completion.
REQ-011 SHALL have port ss_err, output, 1 bit: the last save read a map ID of 8'hff.
REQ-012 SHALL have port map_id, output, 8 bits: the byte captured at address SS_LEN-1 during the last save.
REQ-013 SHALL have port ss_act, output, 1 bit: save-state mode select to the mapper.
REQ-014 SHALL have port ss_we, output, 1 bit: save-state write strobe to the mapper.
REQ-015 SHALL have port ss_addr, output, 8 bits: save-state byte address.
REQ-016 SHALL have port ss_wdat, output, 8 bits: restore data, driven onto the mapper data bus.
REQ-017 SHALL have port ss_rdat, input, 8 bits: mapper save-state read data.
REQ-018 SHALL have port ss_m2, output, 1 bit: m2 clock to the mapper while ss_act=1.
REQ-019 SHALL have port buf_addr, output, 8 bits: buffer RAM address.
REQ-020 SHALL have port buf_we, output, 1 bit: buffer RAM write enable.
REQ-021 SHALL have port buf_wdat, output, 8 bits: buffer RAM write data.
REQ-022 SHALL have port buf_rdat, input, 8 bits: buffer RAM read data, valid 1 cycle after buf_addr.

Function
REQ-023 The FSM SHALL have exactly the states IDLE, SETUP, HIGH, LOW and FIN.
REQ-024 In IDLE, cmd_save SHALL start a save, cmd_load SHALL start a load, and cmd_save SHALL win if both are asserted in the same cycle.
REQ-025 A start SHALL clear the byte index idx to 0, set busy and ss_act on the next cycle, and enter SETUP.
REQ-026 Commands arriving while busy=1 SHALL be ignored (except cmd_abort).
REQ-027 Each byte slot SHALL be: SETUP for 1 cycle (ss_m2=0), then HIGH for M2_HALF cycles (ss_m2=1), then LOW for M2_HALF cycles (ss_m2=0); slot length is 1+2*M2_HALF cycles, 5 by default.
REQ-028 ss_addr and buf_addr SHALL equal idx for the whole slot.
REQ-029 Save: ss_rdat SHALL be captured on the last HIGH cycle, and buf_we=1 with buf_wdat equal to the captured byte SHALL be asserted for the first LOW cycle only.
REQ-030 Save: the byte at idx=SS_LEN-1 SHALL also be loaded into map_id.
REQ-031 Load: buf_rdat SHALL be latched into ss_wdat on the first HIGH cycle and held stable through the end of LOW.
REQ-032 Load: ss_we SHALL be 1 from the second HIGH cycle through the end of LOW, so the mapper's negedge-m2 capture sees stable data; ss_we SHALL be 0 during a save.
REQ-033 At the end of LOW with idx<SS_LEN-1, idx SHALL increment and the FSM SHALL return to SETUP; at idx=SS_LEN-1 the FSM SHALL enter FIN. idx is 8 bits wide and SHALL never wrap.
REQ-034 FIN SHALL last 1 cycle, in which done=1; busy, ss_act and ss_we SHALL be 0 from that same cycle onward, and the FSM SHALL then return to IDLE.
REQ-035 On entering FIN after a save, ss_err SHALL be set to (map_id==8'hff); ss_err SHALL be cleared at the start of each save and kept unchanged by a load.
REQ-036 cmd_abort while busy SHALL be latched and take effect at the end of the current LOW phase, so an m2 pulse is never truncated; it SHALL then go to FIN with aborted=1 instead of done, and ss_err/map_id SHALL NOT update.
REQ-037 cmd_abort in IDLE SHALL be ignored.
REQ-038 Buffer writes SHALL occur only in save LOW cycles, and no mapper write SHALL occur outside ss_act=1.

Reset
REQ-039 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and idx, busy, done, aborted, ss_err, ss_act, ss_we, ss_m2, buf_we SHALL be 0, and ss_addr, buf_addr, ss_wdat, buf_wdat, map_id SHALL be 8'h00.
REQ-040 Reset during a transfer SHALL take effect immediately, even mid-HIGH, with no done or aborted pulse.

Verification
REQ-041 Save with a mapper model returning addr^8'h5A and SS_LEN=128 -> buffer holds addr^8'h5A at 0..127, map_id=8'h25, ss_err=0, done exactly 641 cycles after cmd_save.
REQ-042 Load with buffer=~addr -> the mapper model sees 128 negedge-m2 writes with data=~addr at each address, ss_we never high during a save, done pulses once.
REQ-043 cmd_save and cmd_load asserted in the same cycle -> a save runs; cmd_load pulses during busy -> no effect.
REQ-044 Model returns 8'hff at address 127 -> ss_err=1 after the save; a subsequent load leaves ss_err=1.
REQ-045 cmd_abort during HIGH of byte 10 -> the byte-10 slot completes normally, aborted pulses, done does not pulse, byte 11 is untouched, map_id is unchanged.
REQ-046 rst_n=0 during HIGH of byte 3 of a load -> on the next cycle ss_m2=0, ss_act=0, busy=0, and no further mapper writes occur.
